// File: rtl/cmprs_tx_pkg.sv
// cmprs_tx_pkg: shared types and defaults for the compressor transmit end.
// Optional build macro: CMPRS_TX_TRAILER_EN (bit-count trailer word per block).
package cmprs_tx_pkg;

    localparam int OUT_W_D   = 16;
    localparam int CODE_W_D  = 32;
    localparam int LEN_W_D   = 6;
    localparam int ACC_W_D   = 48;
    localparam int IMG_BIT_W = 31;

    typedef enum logic [1:0] {
        PACK,
        FLUSH,
        TRAIL,
        DONE
    } tx_state_e;

    function automatic logic [IMG_BIT_W-1:0] sat_add(
        input logic [IMG_BIT_W-1:0] a,
        input logic [IMG_BIT_W-1:0] b
    );
        logic [IMG_BIT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[IMG_BIT_W] ? {IMG_BIT_W{1'b1}} : s[IMG_BIT_W-1:0];
    endfunction

endpackage

// File: rtl/cmprs_tx_skid.sv
// cmprs_tx_skid: two-entry valid/ready skid buffer.
// Registered out_valid/out_data with full throughput.
module cmprs_tx_skid #(
    parameter int W = 16
) (
    input  logic         sclk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         empty
);

    logic [W-1:0] sk_data;
    logic         sk_valid;

    assign in_ready = !sk_valid;
    assign empty    = !out_valid && !sk_valid;

    // output register refills from the skid first, then from the input
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            sk_data   <= '0;
            sk_valid  <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (sk_valid) begin
                out_data  <= sk_data;
                out_valid <= 1'b1;
                sk_valid  <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    out_data <= in_data;
                end
            end
        end else if (in_valid && in_ready) begin
            sk_data  <= in_data;
            sk_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/cmprs_transmit.sv
// cmprs_transmit: packs variable-length codewords MSB-first into OUT_W words.
// Optional build macro: CMPRS_TX_TRAILER_EN appends a bit-count trailer word.
module cmprs_transmit
    import cmprs_tx_pkg::*;
#(
    parameter int OUT_W  = OUT_W_D,
    parameter int CODE_W = CODE_W_D,
    parameter int LEN_W  = LEN_W_D,
    parameter int ACC_W  = ACC_W_D
) (
    input  logic                 sclk,
    input  logic                 rst_n,
    input  logic [CODE_W-1:0]    code_data,
    input  logic [LEN_W-1:0]     code_len,
    input  logic                 code_last,
    input  logic                 code_valid,
    output logic                 wfifo_ready,
    input  logic [IMG_BIT_W-1:0] up_img_bit,
    input  logic [IMG_BIT_W-1:0] low_img_bit,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 encode_finish_ready,
    output logic [IMG_BIT_W-1:0] blk_bits,
    output logic                 blk_over,
    output logic                 blk_under
);

    localparam int FILL_W = $clog2(ACC_W + 1) + 1;
    localparam logic [FILL_W-1:0] ACC_F  = FILL_W'(ACC_W);
    localparam logic [FILL_W-1:0] OUT_F  = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] ROOM_F = FILL_W'(ACC_W - CODE_W);
    localparam logic [LEN_W-1:0]  CODE_L = LEN_W'(CODE_W);

    tx_state_e state, state_nx;

    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_nx;
    logic [ACC_W-1:0]     comb_acc;
    logic [ACC_W-1:0]     mask;
    logic [ACC_W-1:0]     code_x;
    logic [FILL_W-1:0]    fill;
    logic [FILL_W-1:0]    fill_nx;
    logic [FILL_W-1:0]    comb_fill;
    logic [FILL_W-1:0]    len_f;
    logic [FILL_W-1:0]    sh;
    logic [LEN_W-1:0]     len_c;
    logic [IMG_BIT_W-1:0] bit_cnt;

    logic             accept;
    logic             emit;
    logic             trl_push;
    logic [OUT_W-1:0] st_data;
    logic             st_valid;
    logic             st_ready;
    logic             st_empty;

`ifdef CMPRS_TX_TRAILER_EN
    logic trl_sent;
`endif

    assign len_c = (code_len > CODE_L) ? CODE_L : code_len;

    assign wfifo_ready = (state == PACK) && (fill <= ROOM_F);
    assign accept      = code_valid && wfifo_ready;

    assign encode_finish_ready = (state == DONE);
    assign st_valid            = emit || trl_push;

    // merge an accepted codeword below the current fill, left-aligned
    always_comb begin
        len_f     = accept ? FILL_W'(len_c) : '0;
        mask      = ~({ACC_W{1'b1}} << len_f);
        code_x    = {{(ACC_W - CODE_W){1'b0}}, code_data} & mask;
        sh        = ACC_F - fill - len_f;
        comb_acc  = acc | (code_x << sh);
        comb_fill = fill + len_f;
        if (emit) begin
            acc_nx  = comb_acc << OUT_W;
            fill_nx = (comb_fill > OUT_F) ? comb_fill - OUT_F : '0;
        end else begin
            acc_nx  = comb_acc;
            fill_nx = comb_fill;
        end
    end

    // block sequencing and word-emit decisions
    always_comb begin
        state_nx = state;
        emit     = 1'b0;
        trl_push = 1'b0;
        st_data  = comb_acc[ACC_W-1 -: OUT_W];
        unique case (state)
            PACK: begin
                emit = (comb_fill >= OUT_F) && st_ready;
                if (accept && code_last) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (fill == '0) begin
                    state_nx = TRAIL;
                end else if (st_ready) begin
                    emit = 1'b1;
                    if (fill <= OUT_F) begin
                        state_nx = TRAIL;
                    end
                end
            end
            TRAIL: begin
`ifdef CMPRS_TX_TRAILER_EN
                if (!trl_sent) begin
                    st_data  = bit_cnt[OUT_W-1:0];
                    trl_push = st_ready;
                end else if (st_empty) begin
                    state_nx = DONE;
                end
`else
                if (st_empty) begin
                    state_nx = DONE;
                end
`endif
            end
            DONE: begin
                state_nx = PACK;
            end
            default: begin
                state_nx = PACK;
            end
        endcase
    end

    // state register
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PACK;
        end else begin
            state <= state_nx;
        end
    end

    // accumulator, bit count and end-of-block budget verdicts
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            fill      <= '0;
            bit_cnt   <= '0;
            blk_bits  <= '0;
            blk_over  <= 1'b0;
            blk_under <= 1'b0;
        end else if (state == DONE) begin
            acc       <= '0;
            fill      <= '0;
            bit_cnt   <= '0;
            blk_bits  <= bit_cnt;
            blk_over  <= (up_img_bit != '0) && (bit_cnt > up_img_bit);
            blk_under <= (low_img_bit != '0) && (bit_cnt < low_img_bit);
        end else begin
            acc  <= acc_nx;
            fill <= fill_nx;
            if (accept) begin
                bit_cnt <= sat_add(bit_cnt, IMG_BIT_W'(len_c));
            end
        end
    end

`ifdef CMPRS_TX_TRAILER_EN
    // remembers that this block's trailer has entered the output stage
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            trl_sent <= 1'b0;
        end else if (state == DONE) begin
            trl_sent <= 1'b0;
        end else if (trl_push) begin
            trl_sent <= 1'b1;
        end
    end
`endif

    a_len_range: assert property (
        @(posedge sclk) disable iff (!rst_n)
        code_valid |-> (code_len <= CODE_L)
    );

    cmprs_tx_skid #(
        .W(OUT_W)
    ) u_skid (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .in_data   (st_data),
        .in_valid  (st_valid),
        .in_ready  (st_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .empty     (st_empty)
    );

endmodule

// File: tb/tb_cmprs_transmit.sv
// tb_cmprs_transmit: bit-queue reference model plus directed and random blocks.
// Follows CMPRS_TX_TRAILER_EN when the design is built with it.
module tb_cmprs_transmit;

    logic        sclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] code_data = '0;
    logic [5:0]  code_len = '0;
    logic        code_last = 1'b0;
    logic        code_valid = 1'b0;
    logic        wfifo_ready;
    logic [30:0] up_img_bit = '0;
    logic [30:0] low_img_bit = '0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        encode_finish_ready;
    logic [30:0] blk_bits;
    logic        blk_over;
    logic        blk_under;

    always #5 sclk = ~sclk;

    cmprs_transmit dut (
        .sclk                (sclk),
        .rst_n               (rst_n),
        .code_data           (code_data),
        .code_len            (code_len),
        .code_last           (code_last),
        .code_valid          (code_valid),
        .wfifo_ready         (wfifo_ready),
        .up_img_bit          (up_img_bit),
        .low_img_bit         (low_img_bit),
        .out_data            (out_data),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .encode_finish_ready (encode_finish_ready),
        .blk_bits            (blk_bits),
        .blk_over            (blk_over),
        .blk_under           (blk_under)
    );

    typedef struct packed {
        logic [30:0] bits;
        logic        over;
        logic        under;
    } blk_t;

    int checks = 0;
    int fails  = 0;
    int n_fin  = 0;
    int bcnt   = 0;
    int rdy_mode = 0;

    bit          pend_bits[$];
    logic [15:0] exp_w[$];
    logic [15:0] got_w[$];
    blk_t        exp_b[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [15:0] gw(input int i);
        if (i < got_w.size()) return got_w[i];
        return 16'hxxxx;
    endfunction

    // model: append accepted bits, cut whole words MSB-first
    task automatic m_push(input logic [31:0] d, input int len);
        logic [15:0] w;
        for (int i = len - 1; i >= 0; i--) pend_bits.push_back(d[i]);
        bcnt += len;
        while (pend_bits.size() >= 16) begin
            for (int i = 0; i < 16; i++) w[15-i] = pend_bits.pop_front();
            exp_w.push_back(w);
        end
    endtask

    // model: pad the remainder, optional trailer, block verdicts
    task automatic m_close();
        logic [15:0] w;
        blk_t b;
        logic [30:0] bc;
        if (pend_bits.size() > 0) begin
            w = '0;
            for (int i = 0; i < pend_bits.size(); i++) w[15-i] = pend_bits[i];
            pend_bits.delete();
            exp_w.push_back(w);
        end
`ifdef CMPRS_TX_TRAILER_EN
        exp_w.push_back(bcnt[15:0]);
`endif
        bc = 31'(bcnt);
        b.bits  = bc;
        b.over  = (up_img_bit != 0) && (bc > up_img_bit);
        b.under = (low_img_bit != 0) && (bc < low_img_bit);
        exp_b.push_back(b);
        bcnt = 0;
    endtask

    task automatic send(input logic [31:0] d, input int len, input bit last);
        int  t;
        bit  ok;
        t  = 0;
        ok = 0;
        code_data  = d;
        code_len   = 6'(len);
        code_last  = last;
        code_valid = 1'b1;
        while (!ok && t < 2000) begin
            @(negedge sclk);
            if (wfifo_ready) ok = 1;
            else begin
                t++;
                @(posedge sclk);
                #1;
            end
        end
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: got no wfifo_ready, expected it within 2000 cycles");
        end else begin
            m_push(d, len);
            if (last) m_close();
        end
        @(posedge sclk);
        #1;
        code_valid = 1'b0;
        code_last  = 1'b0;
    endtask

    task automatic wait_fin(input int target);
        int t;
        t = 0;
        while (n_fin < target && t < 3000) begin
            @(negedge sclk);
            t++;
        end
        chk("finish_seen", 32'(n_fin >= target), 32'd1);
        @(negedge sclk);
        @(posedge sclk);
        #1;
    endtask

    // downstream acceptance pattern
    initial begin
        forever begin
            @(posedge sclk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // per-cycle compare against the model
    initial begin
        bit          stall;
        bit          chk_blk;
        logic [15:0] pd;
        blk_t        cur;
        stall   = 0;
        chk_blk = 0;
        pd      = '0;
        cur     = '0;
        forever begin
            @(negedge sclk);
            if (!rst_n) begin
                stall   = 0;
                chk_blk = 0;
                continue;
            end
            if (chk_blk) begin
                chk("blk_bits", 32'(blk_bits), 32'(cur.bits));
                chk("blk_over", 32'(blk_over), 32'(cur.over));
                chk("blk_under", 32'(blk_under), 32'(cur.under));
                chk_blk = 0;
            end
            if (stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(pd));
            end
            if (out_valid && out_ready) begin
                got_w.push_back(out_data);
                if (exp_w.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL extra_word: got %0h, expected no word", out_data);
                end else begin
                    chk("word", 32'(out_data), 32'(exp_w.pop_front()));
                end
            end
            stall = out_valid && !out_ready;
            pd    = out_data;
            if (encode_finish_ready) begin
                n_fin++;
                chk("words_left_at_finish", 32'(exp_w.size()), 32'd0);
                if (exp_b.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL extra_finish: got a finish pulse, expected none");
                end else begin
                    cur     = exp_b.pop_front();
                    chk_blk = 1;
                end
            end
        end
    end

    initial begin
        int tgt;
        int fin0;
        int n;
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_finish", 32'(encode_finish_ready), 32'd0);
        chk("rst_blk_bits", 32'(blk_bits), 32'd0);
        chk("rst_blk_over", 32'(blk_over), 32'd0);
        chk("rst_blk_under", 32'(blk_under), 32'd0);
        chk("rst_wfifo_ready", 32'(wfifo_ready), 32'd1);
        @(posedge sclk);
        #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        repeat (2) @(posedge sclk);
        #1;

        // four bytes make two words
        got_w.delete();
        tgt = n_fin + 1;
        send(32'hA5, 8, 0);
        send(32'h3C, 8, 0);
        send(32'hFF, 8, 0);
        send(32'h01, 8, 1);
        wait_fin(tgt);
        chk("t1_w0", 32'(gw(0)), 32'hA53C);
        chk("t1_w1", 32'(gw(1)), 32'hFF01);
        chk("t1_bits", 32'(blk_bits), 32'd32);

        // single short codeword is padded
        got_w.delete();
        tgt = n_fin + 1;
        send(32'hFFFF_FFF5, 5, 1);
        wait_fin(tgt);
        chk("t2_w0", 32'(gw(0)), 32'hA800);
        chk("t2_bits", 32'(blk_bits), 32'd5);

        // stalled output holds its word
        rdy_mode = 2;
        repeat (2) @(posedge sclk);
        #1;
        got_w.delete();
        tgt = n_fin + 1;
        send(32'hDEADBEEF, 32, 0);
        send(32'h1234, 16, 1);
        repeat (10) @(negedge sclk);
        chk("t3_hold_valid", 32'(out_valid), 32'd1);
        chk("t3_hold_data", 32'(out_data), 32'hDEAD);
        chk("t3_wfifo_low", 32'(wfifo_ready), 32'd0);
        @(posedge sclk);
        #1;
        rdy_mode = 0;
        wait_fin(tgt);
        chk("t3_w0", 32'(gw(0)), 32'hDEAD);
        chk("t3_w1", 32'(gw(1)), 32'hBEEF);
        chk("t3_w2", 32'(gw(2)), 32'h1234);

        // budget verdicts
        up_img_bit  = 31'd20;
        low_img_bit = 31'd10;
        tgt = n_fin + 1;
        send($urandom, 8, 0);
        send($urandom, 8, 0);
        send($urandom, 8, 1);
        wait_fin(tgt);
        chk("t4_over", 32'(blk_over), 32'd1);
        chk("t4_under", 32'(blk_under), 32'd0);
        tgt = n_fin + 1;
        send($urandom, 8, 1);
        wait_fin(tgt);
        chk("t4b_over", 32'(blk_over), 32'd0);
        chk("t4b_under", 32'(blk_under), 32'd1);

        // zero-bit block
        got_w.delete();
        tgt = n_fin + 1;
        send($urandom, 0, 1);
        wait_fin(tgt);
        chk("t5_bits", 32'(blk_bits), 32'd0);
`ifndef CMPRS_TX_TRAILER_EN
        chk("t5_no_words", 32'(got_w.size()), 32'd0);
`endif

        // reset during flush discards the block
        rdy_mode = 2;
        repeat (2) @(posedge sclk);
        #1;
        send($urandom, 32, 0);
        send($urandom, 16, 1);
        repeat (3) @(posedge sclk);
        #1;
        rst_n = 1'b0;
        exp_w.delete();
        exp_b.delete();
        pend_bits.delete();
        bcnt = 0;
        @(negedge sclk);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        fin0 = n_fin;
        @(posedge sclk);
        #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        repeat (20) @(negedge sclk);
        chk("t6_no_finish", 32'(n_fin), 32'(fin0));
        @(posedge sclk);
        #1;
        got_w.delete();
        tgt = n_fin + 1;
        send(32'hA5, 8, 0);
        send(32'h3C, 8, 1);
        wait_fin(tgt);
        chk("t6_fresh_w0", 32'(gw(0)), 32'hA53C);

        // randomized blocks with random backpressure and budgets
        rdy_mode = 1;
        for (int b = 0; b < 30; b++) begin
            up_img_bit  = ($urandom_range(0, 3) == 0) ? '0 : 31'($urandom_range(1, 150));
            low_img_bit = ($urandom_range(0, 3) == 0) ? '0 : 31'($urandom_range(1, 150));
            n   = $urandom_range(1, 6);
            tgt = n_fin + 1;
            for (int k = 0; k < n; k++) begin
                send($urandom, $urandom_range(0, 32), k == n - 1);
            end
            wait_fin(tgt);
        end

        rdy_mode = 0;
        repeat (5) @(posedge sclk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
